alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: two request ports with a/b/instruction
// payloads and a shared response (result + zero-divide flag) with per-port
// valid/ready handshakes.
`timescale 1ns/1ps
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [31:0] req_instr0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    logic [31:0] req_instr1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_s;
    logic        resp_ze;

    modport master (
        output req_valid, req_a0, req_b0, req_instr0, req_a1, req_b1, req_instr1, resp_ready,
        input  req_ready, resp_valid, resp_s, resp_ze
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_instr0, req_a1, req_b1, req_instr1, resp_ready,
        output req_ready, resp_valid, resp_s, resp_ze
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter/sequencer for a shared combinational 32-bit ALU.
// A granted request's operands are registered onto the ALU inputs, held for an
// op-dependent number of cycles, then the ALU result is captured and returned on
// the originating port. One operation is outstanding at a time.
// Optional feature macro: ALU_ARB_RR_EN (round-robin on contention); when it is
// undefined, port 0 has fixed priority.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [31:0]   alu_instr,
    input  logic [31:0]   alu_s,
    input  logic          alu_ze,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n;
    logic [31:0] cnt_r;
    logic        tag_r;
    logic [31:0] resp_s_r;
    logic        resp_ze_r;
    logic [1:0]  grant_s;
    logic        accept_s;
    logic        capture_s;
    logic        release_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [31:0] sel_instr_s;

    // Hold cycles for an op code; only the low three instruction bits matter.
    function automatic logic [31:0] hold_cycles(input logic [2:0] op);
        logic [31:0] cycles;
        case (op)
            3'b011:  cycles = 32'(MUL_CYCLES);
            3'b111:  cycles = 32'(DIV_CYCLES);
            default: cycles = 32'd1;
        endcase
        return cycles;
    endfunction

`ifdef ALU_ARB_RR_EN
    logic last_r;

    // Round-robin pointer: remembers the port whose response completed last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (release_s) begin
            last_r <= tag_r;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // Grant selection; on contention the round-robin pointer or port 0 decides.
    always_comb begin
        grant_s = 2'b00;
        case (bus.req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
`ifdef ALU_ARB_RR_EN
            2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
`else
            2'b11:   grant_s = 2'b01;
`endif
            default: grant_s = 2'b00;
        endcase
    end

    // Payload multiplexer for the granted port.
    always_comb begin
        if (grant_s[1]) begin
            sel_a_s     = bus.req_a1;
            sel_b_s     = bus.req_b1;
            sel_instr_s = bus.req_instr1;
        end else begin
            sel_a_s     = bus.req_a0;
            sel_b_s     = bus.req_b0;
            sel_instr_s = bus.req_instr0;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    accept_s = 1'b1;
                    state_n  = EXEC;
                end else begin
                    state_n  = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 32'd0) begin
                    capture_s = 1'b1;
                    state_n   = RESP;
                end else begin
                    state_n   = EXEC;
                end
            end
            RESP: begin
                if (bus.resp_ready[tag_r]) begin
                    release_s = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n   = RESP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Operand/tag capture on accept, hold countdown, and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_instr <= 32'd0;
            tag_r     <= 1'b0;
            cnt_r     <= 32'd0;
            resp_s_r  <= 32'd0;
            resp_ze_r <= 1'b0;
        end else begin
            if (accept_s) begin
                alu_a     <= sel_a_s;
                alu_b     <= sel_b_s;
                alu_instr <= sel_instr_s;
                tag_r     <= grant_s[1];
                cnt_r     <= hold_cycles(sel_instr_s[2:0]) - 32'd1;
            end else if ((state_r == EXEC) && (cnt_r != 32'd0)) begin
                cnt_r     <= cnt_r - 32'd1;
            end else begin
                cnt_r     <= cnt_r;
            end
            if (capture_s) begin
                resp_s_r  <= alu_s;
                resp_ze_r <= alu_ze;
            end else begin
                resp_s_r  <= resp_s_r;
                resp_ze_r <= resp_ze_r;
            end
        end
    end

    // Handshake outputs decoded from the registered state and tag.
    always_comb begin
        bus.resp_s  = resp_s_r;
        bus.resp_ze = resp_ze_r;
        busy        = (state_r != IDLE);
        if (state_r == IDLE) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = 2'b00;
        end
        if (state_r == RESP) begin
            bus.resp_valid = tag_r ? 2'b10 : 2'b01;
        end else begin
            bus.resp_valid = 2'b00;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, contention,
// backpressure and reset-mid-op sequences, then randomized traffic checked
// against a cycle-level transaction model.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int MUL_C = 2;
    localparam int DIV_C = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_a, alu_b, alu_instr, alu_s;
    logic        alu_ze, busy;

    always #5 clk = ~clk;

    alu_arbiter_if ifc();

    alu_arbiter #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr),
        .alu_s(alu_s), .alu_ze(alu_ze), .busy(busy)
    );

    // Behavioural ALU: returns {ze, s}.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] instr);
        case (instr[2:0])
            3'd0:    return {1'b0, a + b};
            3'd1:    return {1'b0, a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a * b};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, a ^ b};
            3'd6:    return {1'b0, a << b[4:0]};
            default: return (b == 32'd0) ? {1'b1, 32'd0} : {1'b0, a / b};
        endcase
    endfunction

    function automatic int lat_of(input logic [31:0] instr);
        if (instr[2:0] == 3'b011) return MUL_C;
        if (instr[2:0] == 3'b111) return DIV_C;
        return 1;
    endfunction

    always_comb {alu_ze, alu_s} = alu_ref(alu_a, alu_b, alu_instr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
        if (p == 0) begin
            ifc.req_a0 = a; ifc.req_b0 = b; ifc.req_instr0 = i;
        end else begin
            ifc.req_a1 = a; ifc.req_b1 = b; ifc.req_instr1 = i;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ifc.req_valid = 2'b00;
        ifc.resp_ready = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete operation on port p; lat counts EXEC cycles seen.
    task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] instr,
                          output int lat, output logic [1:0] rv, output logic [31:0] s, output logic ze);
        int k;
        @(negedge clk);
        set_req(p, a, b, instr);
        ifc.req_valid[p] = 1'b1;
        ifc.resp_ready = 2'b00;
        #1;
        k = 0;
        while (!ifc.req_ready[p] && k < 50) begin @(negedge clk); #1; k++; end
        if (k >= 50) timeout("grant_wait");
        @(negedge clk);
        ifc.req_valid = 2'b00;
        #1;
        lat = 0;
        while (ifc.resp_valid == 2'b00 && lat < 50) begin
            check("alu_a_hold", alu_a, a);
            check("alu_instr_hold", alu_instr, instr);
            @(negedge clk); #1; lat++;
        end
        rv = ifc.resp_valid; s = ifc.resp_s; ze = ifc.resp_ze;
        ifc.resp_ready[p] = 1'b1;
        @(negedge clk);
        ifc.resp_ready = 2'b00;
    endtask

    typedef struct {
        int          port;
        logic [31:0] a, b, instr, exp_s;
        logic        exp_ze;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    // Random-phase model state
    logic        pend [2];
    logic [31:0] pa [2], pb [2], pi [2];
    logic        m_busy, m_tag, m_last, m_ze, m_nze;
    int          m_wait;
    logic [31:0] m_a, m_b, m_instr, m_s, m_ns;

    initial begin
        int          lat;
        logic [1:0]  rv;
        logic [31:0] s;
        logic        ze;
        int          grants [4];
        int          ng;
        int          k;
        logic [1:0]  eg;
        logic [31:0] held_s;

        vecs[0] = '{0, 32'd5,      32'd7,      32'h00, 32'd12,     1'b0, 1};
        vecs[1] = '{1, 32'd100,    32'd0,      32'h07, 32'd0,      1'b1, 4};
        vecs[2] = '{0, 32'd6,      32'd7,      32'h03, 32'd42,     1'b0, 2};
        vecs[3] = '{1, 32'd3,      32'd5,      32'h1B, 32'd15,     1'b0, 2};
        vecs[4] = '{0, 32'd20,     32'd3,      32'h17, 32'd6,      1'b0, 4};
        vecs[5] = '{1, 32'd9,      32'd4,      32'h01, 32'd5,      1'b0, 1};
        vecs[6] = '{0, 32'hF0F0,   32'hFF00,   32'h02, 32'hF000,   1'b0, 1};

        ifc.req_valid = 2'b00; ifc.resp_ready = 2'b00;
        set_req(0, 32'd0, 32'd0, 32'd0);
        set_req(1, 32'd0, 32'd0, 32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        check("rst_resp_s", ifc.resp_s, 32'd0);
        check("rst_resp_ze", 32'(ifc.resp_ze), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_instr", alu_instr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].port, vecs[v].a, vecs[v].b, vecs[v].instr, lat, rv, s, ze);
            check("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
            check("vec_resp_valid", 32'(rv), (vecs[v].port == 0) ? 32'd1 : 32'd2);
            check("vec_resp_s", s, vecs[v].exp_s);
            check("vec_resp_ze", 32'(ze), 32'(vecs[v].exp_ze));
        end
        #1;
        check("idle_resp_s_hold", ifc.resp_s, 32'hF000);
        check("idle_busy", 32'(busy), 32'd0);

        // Contention: both ports valid, responses always accepted
        do_reset();
        @(negedge clk);
        set_req(0, 32'd1, 32'd1, 32'h0);
        set_req(1, 32'd2, 32'd2, 32'h0);
        ifc.req_valid = 2'b11;
        ifc.resp_ready = 2'b11;
        ng = 0; k = 0;
        while (ng < 4 && k < 60) begin
            #1;
            if (ifc.req_ready != 2'b00) begin
                check("contention_onehot", 32'($countones(ifc.req_ready)), 32'd1);
                grants[ng] = ifc.req_ready[1] ? 1 : 0;
                ng++;
            end
            @(negedge clk);
            k++;
        end
        if (ng < 4) timeout("contention_grants");
        ifc.req_valid = 2'b00;
        for (int g = 0; g < ng; g++) begin
`ifdef ALU_ARB_RR_EN
            check("contention_grant", 32'(grants[g]), 32'(g % 2));
`else
            check("contention_grant", 32'(grants[g]), 32'd0);
`endif
        end
        repeat (6) @(negedge clk);
        ifc.resp_ready = 2'b00;

        // Backpressure on a port-0 add
        set_req(0, 32'd3, 32'd4, 32'h0);
        ifc.req_valid = 2'b01;
        #1;
        k = 0;
        while (!ifc.req_ready[0] && k < 50) begin @(negedge clk); #1; k++; end
        @(negedge clk);
        ifc.req_valid = 2'b00;
        #1;
        k = 0;
        while (ifc.resp_valid == 2'b00 && k < 50) begin @(negedge clk); #1; k++; end
        if (k >= 50) timeout("bp_resp_wait");
        held_s = ifc.resp_s;
        check("bp_first_s", held_s, 32'd7);
        @(negedge clk);
        ifc.req_valid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_resp_valid", 32'(ifc.resp_valid), 32'd1);
            check("bp_resp_s", ifc.resp_s, held_s);
            check("bp_req_ready", 32'(ifc.req_ready), 32'd0);
            @(negedge clk);
        end
        ifc.req_valid = 2'b00;
        ifc.resp_ready = 2'b01;
        @(negedge clk);
        ifc.resp_ready = 2'b00;
        #1;
        check("bp_done_busy", 32'(busy), 32'd0);
        check("bp_done_resp_valid", 32'(ifc.resp_valid), 32'd0);

        // Reset in the second EXEC cycle of a port-1 multiply
        @(negedge clk);
        set_req(1, 32'd6, 32'd7, 32'h3);
        ifc.req_valid = 2'b10;
        #1;
        k = 0;
        while (!ifc.req_ready[1] && k < 50) begin @(negedge clk); #1; k++; end
        @(negedge clk);
        ifc.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        check("mid_rst_resp_s", ifc.resp_s, 32'd0);
        check("mid_rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        @(negedge clk);
        set_req(0, 32'd1, 32'd2, 32'h0);
        set_req(1, 32'd8, 32'd8, 32'h0);
        ifc.req_valid = 2'b11;
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 32'(ifc.req_ready), 32'd1);
        @(negedge clk);
        ifc.req_valid = 2'b00;
        ifc.resp_ready = 2'b11;
        @(negedge clk); #1;
        check("post_rst_resp_valid", 32'(ifc.resp_valid), 32'd1);
        check("post_rst_resp_s", ifc.resp_s, 32'd3);
        @(negedge clk);
        ifc.resp_ready = 2'b00;

        // Randomized traffic against the transaction model
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_busy = 1'b0; m_last = 1'b1; m_s = 32'd0; m_ze = 1'b0; m_wait = 0;
        m_tag = 1'b0; m_a = 32'd0; m_b = 32'd0; m_instr = 32'd0; m_ns = 32'd0; m_nze = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pa[p] = $urandom();
                    pb[p] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(0, 1000));
                    pi[p] = $urandom();
                    pend[p] = 1'b1;
                    set_req(p, pa[p], pb[p], pi[p]);
                end
                ifc.req_valid[p] = pend[p];
            end
            ifc.resp_ready = 2'($urandom_range(0, 3));
            #1;
            if (!m_busy) begin
                case (ifc.req_valid)
                    2'b01:   eg = 2'b01;
                    2'b10:   eg = 2'b10;
`ifdef ALU_ARB_RR_EN
                    2'b11:   eg = (m_last == 1'b0) ? 2'b10 : 2'b01;
`else
                    2'b11:   eg = 2'b01;
`endif
                    default: eg = 2'b00;
                endcase
                check("rnd_idle_req_ready", 32'(ifc.req_ready), 32'(eg));
                check("rnd_idle_resp_valid", 32'(ifc.resp_valid), 32'd0);
                check("rnd_idle_busy", 32'(busy), 32'd0);
                check("rnd_idle_resp_s", ifc.resp_s, m_s);
                if (eg != 2'b00) begin
                    m_tag = eg[1];
                    m_a = pa[m_tag]; m_b = pb[m_tag]; m_instr = pi[m_tag];
                    {m_nze, m_ns} = alu_ref(m_a, m_b, m_instr);
                    m_wait = lat_of(m_instr);
                    m_busy = 1'b1;
                    pend[m_tag] = 1'b0;
                end
            end else if (m_wait > 0) begin
                check("rnd_exec_busy", 32'(busy), 32'd1);
                check("rnd_exec_req_ready", 32'(ifc.req_ready), 32'd0);
                check("rnd_exec_resp_valid", 32'(ifc.resp_valid), 32'd0);
                check("rnd_exec_alu_a", alu_a, m_a);
                check("rnd_exec_alu_b", alu_b, m_b);
                check("rnd_exec_alu_instr", alu_instr, m_instr);
                m_wait--;
                if (m_wait == 0) begin
                    m_s = m_ns;
                    m_ze = m_nze;
                end
            end else begin
                check("rnd_resp_valid", 32'(ifc.resp_valid), m_tag ? 32'd2 : 32'd1);
                check("rnd_resp_s", ifc.resp_s, m_s);
                check("rnd_resp_ze", 32'(ifc.resp_ze), 32'(m_ze));
                check("rnd_resp_busy", 32'(busy), 32'd1);
                check("rnd_resp_req_ready", 32'(ifc.req_ready), 32'd0);
                if (ifc.resp_ready[m_tag]) begin
                    m_busy = 1'b0;
                    m_last = m_tag;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
